instruction_fetch_unit: RTL and testbench

//  Fetch stage feeding IF_IDRegister: owns the PC, drives a req/ready instruction-memory port, applies branch/jump redirects.

---
 rtl/instruction_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives a req/ready instruction-memory port and presents the fetched word to IF/ID.
// Define FETCH_PERF_CNT_EN to add the PerfFetched_out / PerfBubble_out counters.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_INC   = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall_in,
    input  logic        Redirect_in,
    input  logic [31:0] RedirectPC_in,
    output logic        IMem_Req_out,
    output logic [31:0] IMem_Addr_out,
    input  logic        IMem_Ready_in,
    input  logic [31:0] IMem_Data_in,
    output logic [31:0] Instruction_out,
    output logic [31:0] PCOutput_out,
    output logic [31:0] PCAdderOut_out,
    output logic        Valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] PerfFetched_out,
    output logic [31:0] PerfBubble_out
`endif
);

    localparam logic [31:0] INC = 32'(PC_INC);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] buf_q, buf_d;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            buf_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        case (state_q)
            S_REQ: begin
                if (Redirect_in) begin
                    pc_d = RedirectPC_in;
                    // A request still in flight must complete at its old address before refetching.
                    if (!IMem_Ready_in) begin
                        addr_d  = pc_q;
                        state_d = S_DISCARD;
                    end
                end else if (IMem_Ready_in) begin
                    if (Stall_in) begin
                        buf_d   = IMem_Data_in;
                        state_d = S_HOLD;
                    end else begin
                        pc_d = pc_q + INC;
                    end
                end
            end
            S_HOLD: begin
                if (Redirect_in) begin
                    pc_d    = RedirectPC_in;
                    state_d = S_REQ;
                end else if (!Stall_in) begin
                    pc_d    = pc_q + INC;
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                if (Redirect_in) pc_d = RedirectPC_in;
                if (IMem_Ready_in) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        IMem_Req_out    = 1'b0;
        IMem_Addr_out   = pc_q;
        Valid_out       = 1'b0;
        Instruction_out = 32'h0;
        case (state_q)
            S_REQ: begin
                // Reset forces the FSM to REQ, so gating here keeps Req/Valid low while reset is held.
                IMem_Req_out = Reset;
                Valid_out    = Reset && IMem_Ready_in && !Stall_in && !Redirect_in;
                if (Valid_out) Instruction_out = IMem_Data_in;
            end
            S_HOLD: begin
                Valid_out = !Redirect_in;
                if (Valid_out) Instruction_out = buf_q;
            end
            S_DISCARD: begin
                IMem_Req_out  = 1'b1;
                IMem_Addr_out = addr_q;
            end
            default: ;
        endcase
    end

    assign PCOutput_out   = pc_q;
    assign PCAdderOut_out = pc_q + INC;

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] perf_fetched_q, perf_bubble_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            perf_fetched_q <= 32'h0;
            perf_bubble_q  <= 32'h0;
        end else if (!Stall_in) begin
            if (Valid_out) perf_fetched_q <= sat_inc(perf_fetched_q);
            else           perf_bubble_q  <= sat_inc(perf_bubble_q);
        end
    end

    assign PerfFetched_out = perf_fetched_q;
    assign PerfBubble_out  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, wait states, stall/hold, redirects and PC wrap.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall_in;
    logic        Redirect_in;
    logic [31:0] RedirectPC_in;
    logic        IMem_Ready_in;
    logic [31:0] IMem_Data_in;

    logic        req0, valid0;
    logic [31:0] addr0, instr0, pco0, pca0;
    logic        req1, valid1;
    logic [31:0] addr1, instr1, pco1, pca1;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] pf0, pb0, pf1, pb1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_INC(4)) dut0 (
        .Clk(Clk), .Reset(Reset), .Stall_in(Stall_in), .Redirect_in(Redirect_in),
        .RedirectPC_in(RedirectPC_in), .IMem_Req_out(req0), .IMem_Addr_out(addr0),
        .IMem_Ready_in(IMem_Ready_in), .IMem_Data_in(IMem_Data_in),
        .Instruction_out(instr0), .PCOutput_out(pco0), .PCAdderOut_out(pca0), .Valid_out(valid0)
`ifdef FETCH_PERF_CNT_EN
        , .PerfFetched_out(pf0), .PerfBubble_out(pb0)
`endif
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_INC(4)) dut1 (
        .Clk(Clk), .Reset(Reset), .Stall_in(Stall_in), .Redirect_in(Redirect_in),
        .RedirectPC_in(RedirectPC_in), .IMem_Req_out(req1), .IMem_Addr_out(addr1),
        .IMem_Ready_in(IMem_Ready_in), .IMem_Data_in(IMem_Data_in),
        .Instruction_out(instr1), .PCOutput_out(pco1), .PCAdderOut_out(pca1), .Valid_out(valid1)
`ifdef FETCH_PERF_CNT_EN
        , .PerfFetched_out(pf1), .PerfBubble_out(pb1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic rst_n, input logic stall, input logic redir,
                         input logic [31:0] target, input logic ready, input logic [31:0] data);
        @(negedge Clk);
        Reset         = rst_n;
        Stall_in      = stall;
        Redirect_in   = redir;
        RedirectPC_in = target;
        IMem_Ready_in = ready;
        IMem_Data_in  = data;
        #1;
    endtask

    initial begin
        Reset = 1'b0; Stall_in = 1'b0; Redirect_in = 1'b0;
        RedirectPC_in = 32'h0; IMem_Ready_in = 1'b0; IMem_Data_in = 32'h0;

        // T1: reset state
        drive(1'b0, 0, 0, 32'h0, 1'b1, 32'hAAAA_0000);
        check("rst_req", {31'h0, req0}, 32'h0);
        check("rst_valid", {31'h0, valid0}, 32'h0);
        check("rst_instr", instr0, 32'h0);
        check("rst_pc", pco0, 32'h0);
        check("rst_pcadd", pca0, 32'h4);
        check("rst_pc_wrap", pco1, 32'hFFFF_FFFC);
        check("rst_pcadd_wrap", pca1, 32'h0);

        drive(1'b1, 0, 0, 32'h0, 1'b0, 32'h0);
        check("req_after_rst", {31'h0, req0}, 32'h1);
        check("addr_after_rst", addr0, 32'h0);

        // Reset asserted while the request is outstanding
        drive(1'b0, 0, 0, 32'h0, 1'b0, 32'h0);
        check("midrst_req", {31'h0, req0}, 32'h0);
        check("midrst_valid", {31'h0, valid0}, 32'h0);
        check("midrst_pc", pco0, 32'h0);

        drive(1'b1, 0, 0, 32'h0, 1'b1, 32'hA000_0000);
        check("t1_addr0", addr0, 32'h0);
        check("t1_valid0", {31'h0, valid0}, 32'h1);
        check("t1_instr0", instr0, 32'hA000_0000);
        check("t6_addr_first", addr1, 32'hFFFF_FFFC);
        drive(1'b1, 0, 0, 32'h0, 1'b1, 32'hA000_0004);
        check("t1_addr4", addr0, 32'h4);
        check("t1_valid4", {31'h0, valid0}, 32'h1);
        check("t1_pc4", pco0, 32'h4);
        check("t6_addr_wrap", addr1, 32'h0);
        check("t6_pc_wrap", pco1, 32'h0);
        drive(1'b1, 0, 0, 32'h0, 1'b1, 32'hA000_0008);
        check("t1_addr8", addr0, 32'h8);
        check("t1_valid8", {31'h0, valid0}, 32'h1);
        drive(1'b1, 0, 0, 32'h0, 1'b1, 32'hA000_000C);
        check("t1_addrC", addr0, 32'hC);

        // T2: two wait states at 0x10
        drive(1'b1, 0, 0, 32'h0, 1'b0, 32'h0);
        check("t2_ws1_valid", {31'h0, valid0}, 32'h0);
        check("t2_ws1_addr", addr0, 32'h10);
        check("t2_ws1_req", {31'h0, req0}, 32'h1);
        drive(1'b1, 0, 0, 32'h0, 1'b0, 32'h0);
        check("t2_ws2_valid", {31'h0, valid0}, 32'h0);
        check("t2_ws2_addr", addr0, 32'h10);
        drive(1'b1, 0, 0, 32'h0, 1'b1, 32'h1234_5678);
        check("t2_valid", {31'h0, valid0}, 32'h1);
        check("t2_instr", instr0, 32'h1234_5678);
        check("t2_pc", pco0, 32'h10);
        check("t2_pcadd", pca0, 32'h14);
`ifdef FETCH_PERF_CNT_EN
        check("t6_perf_bubble", pb0, 32'd2);
        check("t6_perf_fetched", pf0, 32'd4);
`endif
        drive(1'b1, 0, 0, 32'h0, 1'b1, 32'hB000_0014);
        check("seq_addr14", addr0, 32'h14);
        drive(1'b1, 0, 0, 32'h0, 1'b1, 32'hB000_0018);
        check("seq_addr18", addr0, 32'h18);
        drive(1'b1, 0, 0, 32'h0, 1'b1, 32'hB000_001C);
        check("seq_addr1C", addr0, 32'h1C);

        // T3: stall when data returns at 0x20
        drive(1'b1, 1, 0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        check("t3_capture_addr", addr0, 32'h20);
        check("t3_capture_valid", {31'h0, valid0}, 32'h0);
        check("t3_capture_instr", instr0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1, 0, 32'h0, 1'b0, 32'h5555_5555);
            check("t3_hold_req", {31'h0, req0}, 32'h0);
            check("t3_hold_valid", {31'h0, valid0}, 32'h1);
            check("t3_hold_instr", instr0, 32'hDEAD_BEEF);
            check("t3_hold_pc", pco0, 32'h20);
        end
        drive(1'b1, 0, 0, 32'h0, 1'b0, 32'h0);
        check("t3_release_valid", {31'h0, valid0}, 32'h1);
        check("t3_release_instr", instr0, 32'hDEAD_BEEF);
        drive(1'b1, 0, 0, 32'h0, 1'b0, 32'h0);
        check("t3_next_req", {31'h0, req0}, 32'h1);
        check("t3_next_addr", addr0, 32'h24);

        // T4: redirect while holding, with Stall still high
        drive(1'b1, 1, 0, 32'h0, 1'b1, 32'hCAFE_0024);
        check("t4_capture_valid", {31'h0, valid0}, 32'h0);
        drive(1'b1, 1, 1, 32'h100, 1'b0, 32'h0);
        check("t4_redir_valid", {31'h0, valid0}, 32'h0);
        check("t4_redir_instr", instr0, 32'h0);
        drive(1'b1, 0, 0, 32'h0, 1'b0, 32'h0);
        check("t4_next_req", {31'h0, req0}, 32'h1);
        check("t4_next_addr", addr0, 32'h100);

        // Redirect in REQ with Ready=1: data dropped, go straight to the target
        drive(1'b1, 0, 1, 32'h40, 1'b1, 32'hBAD0_0100);
        check("redir_ready_valid", {31'h0, valid0}, 32'h0);

        // T5: redirect during a wait state at 0x40
        drive(1'b1, 0, 1, 32'h200, 1'b0, 32'h0);
        check("t5_redir_addr", addr0, 32'h40);
        check("t5_redir_valid", {31'h0, valid0}, 32'h0);
        drive(1'b1, 0, 0, 32'h0, 1'b0, 32'h0);
        check("t5_disc_addr", addr0, 32'h40);
        check("t5_disc_req", {31'h0, req0}, 32'h1);
        check("t5_disc_valid", {31'h0, valid0}, 32'h0);
        drive(1'b1, 0, 0, 32'h0, 1'b1, 32'hBAD0_0040);
        check("t5_drop_addr", addr0, 32'h40);
        check("t5_drop_valid", {31'h0, valid0}, 32'h0);
        check("t5_drop_instr", instr0, 32'h0);
        drive(1'b1, 0, 0, 32'h0, 1'b1, 32'h600D_0200);
        check("t5_target_addr", addr0, 32'h200);
        check("t5_target_valid", {31'h0, valid0}, 32'h1);
        check("t5_target_instr", instr0, 32'h600D_0200);
        check("t5_target_pcadd", pca0, 32'h204);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
